mtsp_gprs_mt: RTL



---
 rtl/mtsp_gprs_pkg.sv | 29 ++
 rtl/mtsp_gprs_lane_ram.sv | 54 +++++
 rtl/mtsp_gprs_mt.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mtsp_gprs_pkg.sv
// mtsp_gprs_pkg: shared types and helpers for the MTSP register file.
// Default geometry, lane/register types, FSM states, entry mapping.
package mtsp_gprs_pkg;

    localparam int unsigned DEF_NUM_THREADS = 12;
    localparam int unsigned DEF_GPR_DEPTH   = 64;
    localparam int unsigned DEF_LANES       = 4;
    localparam int unsigned DEF_LANE_W      = 32;
    localparam int unsigned DEF_RD_PORTS    = 4;
    localparam int unsigned DEF_WR_PORTS    = 2;

    typedef logic [DEF_LANE_W-1:0] lane_t;
    typedef lane_t [DEF_LANES-1:0] reg_t;
    typedef logic [DEF_LANES-1:0]  mask_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } gprs_state_e;

    function automatic int unsigned entry_index(
        input int unsigned tid,
        input int unsigned addr,
        input int unsigned depth
    );
        return tid * depth + addr;
    endfunction

endpackage

// File: rtl/mtsp_gprs_lane_ram.sv
// mtsp_gprs_lane_ram: one DWORD lane of the register file.
// Multi-port masked write (higher port wins), registered reads.
module mtsp_gprs_lane_ram #(
    parameter int unsigned ENTRIES  = 768,
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned LANE_W   = 32,
    parameter int unsigned RD_PORTS = 4,
    parameter int unsigned WR_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_en,
    input  logic [IDX_W-1:0]             clr_idx,
    input  logic [WR_PORTS-1:0]          wr_en,
    input  logic [WR_PORTS*IDX_W-1:0]    wr_idx,
    input  logic [WR_PORTS*LANE_W-1:0]   wr_data,
    input  logic [RD_PORTS-1:0]          rd_load,
    input  logic [RD_PORTS-1:0]          rd_zero,
    input  logic [RD_PORTS*IDX_W-1:0]    rd_idx,
    output logic [RD_PORTS*LANE_W-1:0]   rd_data
);

    logic [LANE_W-1:0] mem [ENTRIES];

    // Storage update: clear engine owns the array, else ports in
    // ascending order so the highest enabled port lands last.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int j = 0; j < WR_PORTS; j++) begin
                if (wr_en[j]) begin
                    mem[wr_idx[j*IDX_W +: IDX_W]] <=
                        wr_data[j*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Output register per read port; holds value between loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < RD_PORTS; i++) begin
                if (rd_load[i]) begin
                    rd_data[i*LANE_W +: LANE_W] <= rd_zero[i] ? '0 :
                        mem[rd_idx[i*IDX_W +: IDX_W]];
                end
            end
        end
    end

endmodule

// File: rtl/mtsp_gprs_mt.sv
// mtsp_gprs_mt: multi-thread GPR file with zero-fill clear engine.
// Thread-addressed reads (2-stage), per-lane masked writes.
module mtsp_gprs_mt
    import mtsp_gprs_pkg::*;
#(
    parameter int          CORE_ID     = 0,
    parameter int unsigned NUM_THREADS = DEF_NUM_THREADS,
    parameter int unsigned GPR_DEPTH   = DEF_GPR_DEPTH,
    parameter int unsigned LANES       = DEF_LANES,
    parameter int unsigned LANE_W      = DEF_LANE_W,
    parameter int unsigned RD_PORTS    = DEF_RD_PORTS,
    parameter int unsigned WR_PORTS    = DEF_WR_PORTS,
    localparam int unsigned TID_W =
        (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int unsigned ADDR_W =
        (GPR_DEPTH > 1) ? $clog2(GPR_DEPTH) : 1,
    localparam int unsigned RW = LANES * LANE_W
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         CLEAR_REQ,
    output logic                         BUSY,
    input  logic [RD_PORTS-1:0]          RD_nEN,
    input  logic [RD_PORTS*TID_W-1:0]    RD_TID,
    input  logic [RD_PORTS*ADDR_W-1:0]   RD_ADDR,
    output logic [RD_PORTS-1:0]          RD_VALID,
    output logic [RD_PORTS*RW-1:0]       RD_DATA,
    input  logic [WR_PORTS-1:0]          WR_nEN,
    input  logic [WR_PORTS*LANES-1:0]    WR_MASK,
    input  logic [WR_PORTS*TID_W-1:0]    WR_TID,
    input  logic [WR_PORTS*ADDR_W-1:0]   WR_ADDR,
    input  logic [WR_PORTS*RW-1:0]       WR_DATA
);

    localparam int unsigned ENTRIES = NUM_THREADS * GPR_DEPTH;
    localparam int unsigned IDX_W =
        (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);
    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_READY = READY;

    if (GPR_DEPTH == 0 || (GPR_DEPTH & (GPR_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("GPR_DEPTH must be a power of 2");
    end
    if (RD_PORTS < 1 || WR_PORTS < 1) begin : g_chk_ports
        $error("RD_PORTS and WR_PORTS must be at least 1");
    end
    if (NUM_THREADS < 1) begin : g_chk_thr
        $error("NUM_THREADS must be at least 1");
    end
    if (CORE_ID < 0) begin : g_chk_core
        $error("CORE_ID must be non-negative");
    end

    logic [0:0]       state;
    logic [IDX_W-1:0] clr_cnt;
    logic             busy;
    logic             flush;

    assign busy  = (state == ST_CLEAR);
    assign flush = busy | CLEAR_REQ;
    assign BUSY  = busy;

    // Clear engine: one entry per cycle, restartable by CLEAR_REQ.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (CLEAR_REQ) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == LAST) begin
                state   <= ST_READY;
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    logic [WR_PORTS-1:0]       wr_ok;
    logic [WR_PORTS*IDX_W-1:0] wr_idx;

    for (genvar j = 0; j < WR_PORTS; j++) begin : g_wr
        logic [TID_W-1:0]  tid;
        logic [ADDR_W-1:0] addr;
        assign tid  = WR_TID[j*TID_W +: TID_W];
        assign addr = WR_ADDR[j*ADDR_W +: ADDR_W];
        assign wr_ok[j] = ~WR_nEN[j] & ~busy &
            (32'(tid) < NUM_THREADS);
        assign wr_idx[j*IDX_W +: IDX_W] = IDX_W'(
            entry_index(32'(tid), 32'(addr), GPR_DEPTH));
    end

    logic [RD_PORTS-1:0]       rd_oor;
    logic [RD_PORTS*IDX_W-1:0] rd_idx_d;

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        logic [TID_W-1:0]  tid;
        logic [ADDR_W-1:0] addr;
        assign tid  = RD_TID[i*TID_W +: TID_W];
        assign addr = RD_ADDR[i*ADDR_W +: ADDR_W];
        assign rd_oor[i] = (32'(tid) >= NUM_THREADS);
        assign rd_idx_d[i*IDX_W +: IDX_W] = rd_oor[i] ? '0 :
            IDX_W'(entry_index(32'(tid), 32'(addr), GPR_DEPTH));
    end

    logic [RD_PORTS-1:0]       rd_v1;
    logic [RD_PORTS-1:0]       rd_v2;
    logic [RD_PORTS-1:0]       rd_zero_q;
    logic [RD_PORTS*IDX_W-1:0] rd_idx_q;
    logic [RD_PORTS-1:0]       rd_load;

    assign rd_load  = rd_v1 & {RD_PORTS{~flush}};
    assign RD_VALID = rd_v2;

    // Read address stage and valid pipe; clearing aborts reads.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_v1     <= '0;
            rd_v2     <= '0;
            rd_zero_q <= '0;
            rd_idx_q  <= '0;
        end else begin
            rd_v1 <= ~RD_nEN & {RD_PORTS{~flush}};
            rd_v2 <= rd_load;
            for (int i = 0; i < RD_PORTS; i++) begin
                if (!RD_nEN[i] && !flush) begin
                    rd_idx_q[i*IDX_W +: IDX_W] <=
                        rd_idx_d[i*IDX_W +: IDX_W];
                    rd_zero_q[i] <= rd_oor[i];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WR_PORTS-1:0]        wen;
        logic [WR_PORTS*LANE_W-1:0] wdat;
        logic [RD_PORTS*LANE_W-1:0] rdat;

        for (genvar j = 0; j < WR_PORTS; j++) begin : g_w
            assign wen[j] = wr_ok[j] & WR_MASK[j*LANES + l];
            assign wdat[j*LANE_W +: LANE_W] =
                WR_DATA[(j*LANES + l)*LANE_W +: LANE_W];
        end

        mtsp_gprs_lane_ram #(
            .ENTRIES  (ENTRIES),
            .IDX_W    (IDX_W),
            .LANE_W   (LANE_W),
            .RD_PORTS (RD_PORTS),
            .WR_PORTS (WR_PORTS)
        ) u_ram (
            .clk     (CLK),
            .rst_n   (nRST),
            .clr_en  (busy),
            .clr_idx (clr_cnt),
            .wr_en   (wen),
            .wr_idx  (wr_idx),
            .wr_data (wdat),
            .rd_load (rd_load),
            .rd_zero (rd_zero_q),
            .rd_idx  (rd_idx_q),
            .rd_data (rdat)
        );

        for (genvar i = 0; i < RD_PORTS; i++) begin : g_r
            assign RD_DATA[(i*LANES + l)*LANE_W +: LANE_W] =
                rdat[i*LANE_W +: LANE_W];
        end
    end

endmodule
